// File: rtl/spi_counter_rx_if.sv
// ---------------------------------------------------------------------------
// spi_counter_rx_if
//   The four SPI board pins shared by the counter master and the slave.
//   sclk : SPI clock, idle low, asynchronous to the slave's system clock
//   mosi : master-out data, MSB first
//   cs_n : chip select, active low
//   miso : slave-out data (loopback of the previously held counter)
// ---------------------------------------------------------------------------
interface spi_counter_rx_if;
   logic sclk;
   logic mosi;
   logic cs_n;
   logic miso;

   modport master (output sclk, output mosi, output cs_n, input  miso);
   modport slave  (input  sclk, input  mosi, input  cs_n, output miso);
endinterface

// File: rtl/spi_counter_rx.sv
// ---------------------------------------------------------------------------
// spi_counter_rx
//   SPI mode-0 slave. Receives 16-bit frames carrying a counter value, keeps
//   the low 14 bits (saturated to MAX_COUNT) as a stable display value, and
//   shifts the previously held value back out on MISO. All SPI pins are
//   oversampled in the clk domain.
//
//   clk         : system clock
//   rst         : asynchronous active-high reset
//   spi         : SPI pins (slave modport)
//   counter_o   : last accepted value, changes only on rx_done_o
//   rx_done_o   : one-cycle pulse when counter_o updates
//   frame_err_o : one-cycle pulse when cs_n rises before 16 bits arrived
//   ovf_o       : one-cycle pulse with rx_done_o when saturation was applied
// ---------------------------------------------------------------------------
module spi_counter_rx #(
   parameter int SYNC_STAGES = 2,
   parameter int MAX_COUNT   = 9999
) (
   input  logic             clk,
   input  logic             rst,
   spi_counter_rx_if.slave  spi,
   output logic [13:0]      counter_o,
   output logic             rx_done_o,
   output logic             frame_err_o,
   output logic             ovf_o
);

   typedef enum logic [1:0] {IDLE, RECV, LATCH, WAIT_CS} state_t;

   // ---- pin synchronizers + one extra flop for edge detection ----
   logic [SYNC_STAGES-1:0] sclk_sync_q, mosi_sync_q, csn_sync_q;
   logic                   sclk_prev_q, csn_prev_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sclk_sync_q <= '0;
         mosi_sync_q <= '0;
         csn_sync_q  <= '1;   // idle-high so reset release never looks like a select
         sclk_prev_q <= 1'b0;
         csn_prev_q  <= 1'b1;
      end else begin
         sclk_sync_q <= (sclk_sync_q << 1) | SYNC_STAGES'(spi.sclk);
         mosi_sync_q <= (mosi_sync_q << 1) | SYNC_STAGES'(spi.mosi);
         csn_sync_q  <= (csn_sync_q  << 1) | SYNC_STAGES'(spi.cs_n);
         sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
         csn_prev_q  <= csn_sync_q[SYNC_STAGES-1];
      end
   end

   logic sclk_s, mosi_s, csn_s;
   logic sclk_rise, sclk_fall, csn_fall, csn_rise;

   assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
   assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
   assign csn_s     = csn_sync_q[SYNC_STAGES-1];
   assign sclk_rise =  sclk_s & ~sclk_prev_q;
   assign sclk_fall = ~sclk_s &  sclk_prev_q;
   assign csn_fall  = ~csn_s  &  csn_prev_q;
   assign csn_rise  =  csn_s  & ~csn_prev_q;

   // ---- frame state ----
   state_t      state_q;
   logic [4:0]  bit_cnt_q;
   // Only the last 14 bits shifted in are ever used, so bits [15:14] of the
   // frame simply fall off the top of this register.
   logic [13:0] rx_shift_q;
   logic [15:0] tx_shift_q;
   logic [13:0] counter_q;
   logic        rx_done_q, frame_err_q, ovf_q;

   // Saturated value presented to the LATCH state.
   logic [13:0] counter_d;
   logic        ovf_d;

   always_comb begin
      ovf_d     = (rx_shift_q > 14'(MAX_COUNT));
      counter_d = ovf_d ? 14'(MAX_COUNT) : rx_shift_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         bit_cnt_q   <= '0;
         rx_shift_q  <= '0;
         tx_shift_q  <= '0;
         counter_q   <= '0;
         rx_done_q   <= 1'b0;
         frame_err_q <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         rx_done_q   <= 1'b0;
         frame_err_q <= 1'b0;
         ovf_q       <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (csn_fall) begin
                  bit_cnt_q  <= '0;
                  rx_shift_q <= '0;
                  tx_shift_q <= {2'b00, counter_q};
                  state_q    <= RECV;
               end
            end
            RECV: begin
               // bit_cnt is always < 16 while in RECV, so any deselect is an abort.
               if (csn_rise) begin
                  frame_err_q <= 1'b1;
                  state_q     <= IDLE;
               end else if (sclk_rise) begin
                  // A rise wins over a coincident fall.
                  rx_shift_q <= {rx_shift_q[12:0], mosi_s};
                  bit_cnt_q  <= bit_cnt_q + 5'd1;
                  if (bit_cnt_q == 5'd15)
                     state_q <= LATCH;
               end else if (sclk_fall) begin
                  tx_shift_q <= {tx_shift_q[14:0], 1'b0};
               end
            end
            LATCH: begin
               counter_q <= counter_d;
               ovf_q     <= ovf_d;
               rx_done_q <= 1'b1;
               state_q   <= WAIT_CS;
            end
            WAIT_CS: begin
               if (csn_s)
                  state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign spi.miso    = ~csn_s & tx_shift_q[15];
   assign counter_o   = counter_q;
   assign rx_done_o   = rx_done_q;
   assign frame_err_o = frame_err_q;
   assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_spi_counter_rx.sv
// ---------------------------------------------------------------------------
// tb_spi_counter_rx
//   Drives SPI frames at SCLK = clk/8 and compares the slave against a
//   frame-level model: accepted value = min(frame[13:0], 9999), MISO returns
//   {2'b00, previous value}, short frames raise frame_err and keep the value.
// ---------------------------------------------------------------------------
module tb_spi_counter_rx;
   localparam int MAXC = 9999;

   logic        clk = 1'b0;
   logic        rst;
   logic [13:0] counter;
   logic        rx_done, frame_err, ovf;

   spi_counter_rx_if spi();

   always #5 clk = ~clk;

   spi_counter_rx #(.SYNC_STAGES(2), .MAX_COUNT(MAXC)) dut (
      .clk         (clk),
      .rst         (rst),
      .spi         (spi),
      .counter_o   (counter),
      .rx_done_o   (rx_done),
      .frame_err_o (frame_err),
      .ovf_o       (ovf)
   );

   int          n_checks = 0, n_errors = 0;
   int          n_done = 0, n_ovf = 0, n_ferr = 0;
   int          exp_cnt = 0;
   logic [13:0] prev_cnt = '0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Pulse counting plus the rule that counter only moves with rx_done.
   always @(negedge clk) begin
      if (!rst) begin
         if (rx_done) n_done++;
         if (frame_err) n_ferr++;
         if (ovf) begin
            n_ovf++;
            chk("ovf_with_done", 32'(rx_done), 32'd1);
         end
         if (counter !== prev_cnt) chk("cnt_moves_on_done", 32'(rx_done), 32'd1);
      end
      prev_cnt = counter;
   end

   task automatic clk_n(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Select, then clock nbits bits; MISO is sampled just before each rise.
   task automatic shift_bits(input logic [15:0] val, input int nbits, output logic [15:0] rx);
      rx = '0;
      spi.cs_n = 1'b0;
      clk_n(6);
      for (int i = 0; i < nbits; i++) begin
         spi.mosi = (i < 16) ? val[15-i] : 1'($urandom);
         clk_n(4);
         if (i < 16) rx[15-i] = spi.miso;
         spi.sclk = 1'b1;
         clk_n(4);
         spi.sclk = 1'b0;
      end
      clk_n(4);
   endtask

   task automatic frame(input logic [15:0] val, input int nbits, input string tag);
      logic [15:0] rx;
      int          d0, o0, e0, prev_model, exp_ovf;
      d0 = n_done; o0 = n_ovf; e0 = n_ferr;
      prev_model = exp_cnt;
      shift_bits(val, nbits, rx);
      spi.cs_n = 1'b1;
      clk_n(8);
      if (nbits >= 16) begin
         exp_ovf = (int'(val[13:0]) > MAXC) ? 1 : 0;
         exp_cnt = exp_ovf ? MAXC : int'(val[13:0]);
         chk({tag, "_miso"}, 32'(rx), 32'(prev_model));
         chk({tag, "_done"}, 32'(n_done - d0), 32'd1);
         chk({tag, "_ovf"},  32'(n_ovf - o0),  32'(exp_ovf));
         chk({tag, "_ferr"}, 32'(n_ferr - e0), 32'd0);
      end else begin
         chk({tag, "_done"}, 32'(n_done - d0), 32'd0);
         chk({tag, "_ovf"},  32'(n_ovf - o0),  32'd0);
         chk({tag, "_ferr"}, 32'(n_ferr - e0), 32'd1);
      end
      chk({tag, "_cnt"}, 32'(counter), 32'(exp_cnt));
      chk({tag, "_miso_idle"}, 32'(spi.miso), 32'd0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] rx;
      int          e0, r, nb;
      rst = 1'b1;
      spi.cs_n = 1'b1; spi.sclk = 1'b0; spi.mosi = 1'b0;
      clk_n(5);
      chk("rst_cnt",  32'(counter),   32'd0);
      chk("rst_done", 32'(rx_done),   32'd0);
      chk("rst_ferr", 32'(frame_err), 32'd0);
      chk("rst_ovf",  32'(ovf),       32'd0);
      chk("rst_miso", 32'(spi.miso),  32'd0);
      rst = 1'b0;
      clk_n(5);

      frame(16'h04D2, 16, "f1234");
      frame(16'hC00A, 16, "f_hi_ign");
      frame(16'h3FFF, 16, "f_sat");
      frame(16'h270F, 16, "f_max");
      frame(16'h0055, 9,  "f_abort");
      frame(16'h0007, 16, "f7");
      frame(16'h0100, 18, "f_extra");

      // Reset in the middle of a frame: value clears, no frame_err.
      e0 = n_ferr;
      shift_bits(16'h1234, 8, rx);
      rst = 1'b1;
      spi.cs_n = 1'b1; spi.sclk = 1'b0;
      clk_n(1);
      chk("midrst_cnt",  32'(counter),  32'd0);
      chk("midrst_miso", 32'(spi.miso), 32'd0);
      clk_n(4);
      rst = 1'b0;
      exp_cnt = 0;
      clk_n(8);
      chk("midrst_ferr", 32'(n_ferr - e0), 32'd0);
      frame(16'h0063, 16, "f99");

      for (int k = 0; k < 30; k++) begin
         r  = $urandom_range(0, 9);
         nb = (r < 2) ? $urandom_range(1, 15) : (r < 4) ? $urandom_range(17, 20) : 16;
         frame(16'($urandom), nb, "rnd");
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
